// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the single-port data RAM: picks a requester in IDLE,
// runs one RAM access (BUS), then acknowledges it (DONE).
module ram_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 0,
    parameter int FIXED_PRIO = 0
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iM0_REQ,
    input  logic          iM0_WR,
    input  logic [AW-1:0] iM0_ADDR,
    input  logic [DW-1:0] iM0_WDATA,
    output logic          oM0_ACK,
    output logic [DW-1:0] oM0_RDATA,
    input  logic          iM1_REQ,
    input  logic          iM1_WR,
    input  logic [AW-1:0] iM1_ADDR,
    input  logic [DW-1:0] iM1_WDATA,
    output logic          oM1_ACK,
    output logic [DW-1:0] oM1_RDATA,
    output logic          oRAM_CE,
    output logic          oRAM_RD,
    output logic          oRAM_WR,
    output logic [AW-1:0] oRAM_ADDR,
    output logic [DW-1:0] oRAM_DATA,
    input  logic [DW-1:0] iRAM_DATA,
    output logic          oBUSY,
    output logic          oOWNER
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    localparam logic [1:0] LAST_CNT = 2'(RD_LATENCY);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          cmd_wr_q, cmd_wr_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          grant_m1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cnt_d       = cnt_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        // On a tie, round-robin hands M1 the bus only if M0 was served last
        grant_m1    = iM1_REQ && (!iM0_REQ || (FIXED_PRIO == 0 && !last_q));
        case (state_q)
            S_IDLE: begin
                if (iM0_REQ || iM1_REQ) begin
                    owner_d     = grant_m1;
                    cmd_wr_d    = grant_m1 ? iM1_WR    : iM0_WR;
                    cmd_addr_d  = grant_m1 ? iM1_ADDR  : iM0_ADDR;
                    cmd_wdata_d = grant_m1 ? iM1_WDATA : iM0_WDATA;
                    cnt_d       = 2'd0;
                    state_d     = S_BUS;
                end
            end
            S_BUS: begin
                if (cmd_wr_q || cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    if (!cmd_wr_q) begin
                        if (owner_q) rdata1_d = iRAM_DATA;
                        else         rdata0_d = iRAM_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cnt_q       <= 2'd0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cnt_q       <= cnt_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // ADDR/DATA come straight from the command register so they hold between accesses
    assign oRAM_CE   = (state_q == S_BUS);
    assign oRAM_RD   = oRAM_CE && !cmd_wr_q;
    assign oRAM_WR   = oRAM_CE && cmd_wr_q;
    assign oRAM_ADDR = cmd_addr_q;
    assign oRAM_DATA = cmd_wdata_q;
    assign oM0_ACK   = (state_q == S_DONE) && !owner_q;
    assign oM1_ACK   = (state_q == S_DONE) && owner_q;
    assign oM0_RDATA = rdata0_q;
    assign oM1_RDATA = rdata1_q;
    assign oBUSY     = (state_q != S_IDLE);
    assign oOWNER    = owner_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two configurations (latency 0 round-robin, latency 2 fixed
// priority), each with a RAM model, two masters, a transaction-level arbiter model and a monitor.
module tb_ram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct {
        int            m;
        int            g;
        int            a;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        if (a == 8'h7F) return 32'h12345678;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 8'h10;
            1:       return 8'h20;
            2:       return 8'h01;
            3:       return 8'h7F;
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int L  = (g == 0) ? 0 : 2;
        localparam int FP = (g == 0) ? 0 : 1;

        logic          rst;
        logic          req   [2];
        logic          wr    [2];
        logic [AW-1:0] addr  [2];
        logic [DW-1:0] wdata [2];
        logic          ack   [2];
        logic [DW-1:0] rdata [2];
        logic          ce, rd, we, busy, owner;
        logic [AW-1:0] raddr;
        logic [DW-1:0] rdo, rdi;

        bit   done;
        bit   scrib [2];
        int   iss   [2];
        int   gnt   [2];
        txn_t q[$];

        ram_port_arbiter #(.AW(AW), .DW(DW), .RD_LATENCY(L), .FIXED_PRIO(FP)) dut (
            .iCLK(clk), .iRST(rst),
            .iM0_REQ(req[0]), .iM0_WR(wr[0]), .iM0_ADDR(addr[0]), .iM0_WDATA(wdata[0]),
            .oM0_ACK(ack[0]), .oM0_RDATA(rdata[0]),
            .iM1_REQ(req[1]), .iM1_WR(wr[1]), .iM1_ADDR(addr[1]), .iM1_WDATA(wdata[1]),
            .oM1_ACK(ack[1]), .oM1_RDATA(rdata[1]),
            .oRAM_CE(ce), .oRAM_RD(rd), .oRAM_WR(we), .oRAM_ADDR(raddr), .oRAM_DATA(rdo),
            .iRAM_DATA(rdi), .oBUSY(busy), .oOWNER(owner)
        );

        // RAM: data only valid once RD has been held for L cycles
        logic [DW-1:0] ram   [256];
        bit            ram_w [256];
        int            rd_run = 0;
        always @(posedge clk) begin
            if (ce && we) begin
                ram[raddr]   <= rdo;
                ram_w[raddr] <= 1'b1;
            end
            rd_run <= (ce && rd) ? rd_run + 1 : 0;
        end
        assign rdi = (rd_run < L) ? 32'hBAD0BAD0 : (ram_w[raddr] ? ram[raddr] : init_val(raddr));

        // Arbiter model: one transaction at a time, next grant one cycle after the ACK
        int free_c = 0;
        int last   = 1;
        always @(posedge clk) begin
            #2;
            if (rst) begin
                free_c = cyc + 1;
                last   = 1;
                gnt[0] = iss[0];
                gnt[1] = iss[1];
            end else if (cyc >= free_c && (iss[0] != gnt[0] || iss[1] != gnt[1])) begin
                txn_t t;
                int   w;
                bit   p0, p1;
                p0 = (iss[0] != gnt[0]);
                p1 = (iss[1] != gnt[1]);
                if (p0 && p1) w = (FP != 0) ? 0 : ((last == 0) ? 1 : 0);
                else          w = p0 ? 0 : 1;
                t.m    = w;
                t.g    = cyc;
                t.wr   = wr[w];
                t.addr = addr[w];
                t.data = wdata[w];
                t.a    = cyc + 2 + (wr[w] ? 0 : L);
                free_c = t.a + 1;
                last   = w;
                gnt[w] = iss[w];
                q.push_back(t);
            end
        end

        // Monitor: derives every expected output from the head transaction
        logic [DW-1:0] exp_rd [2];
        logic          exp_own;
        bit            armed;
        logic [DW-1:0] ref_v [256];
        bit            ref_w [256];
        always @(negedge clk) begin
            txn_t hd;
            bit   act, ce_e, fin;
            logic ack_e0, ack_e1;
            if (armed) begin
                act = 1'b0;
                ce_e = 1'b0;
                fin = 1'b0;
                if (q.size() > 0) begin
                    hd  = q[0];
                    act = (cyc > hd.g);
                end
                if (act) begin
                    exp_own = hd.m[0];
                    ce_e    = (cyc < hd.a);
                    fin     = (cyc == hd.a);
                end
                ack_e0 = fin && hd.m == 0;
                ack_e1 = fin && hd.m == 1;
                if (fin) begin
                    if (hd.wr) begin
                        ref_v[hd.addr] = hd.data;
                        ref_w[hd.addr] = 1'b1;
                    end else begin
                        exp_rd[hd.m] = ref_w[hd.addr] ? ref_v[hd.addr] : init_val(hd.addr);
                    end
                end
                chk($sformatf("h%0d ce/rd/wr/busy/owner/ack0/ack1", g),
                    {57'b0, ce, rd, we, busy, owner, ack[0], ack[1]},
                    {57'b0, ce_e, ce_e && !hd.wr, ce_e && hd.wr, act, exp_own, ack_e0, ack_e1});
                chk($sformatf("h%0d rdata0", g), {32'b0, rdata[0]}, {32'b0, exp_rd[0]});
                chk($sformatf("h%0d rdata1", g), {32'b0, rdata[1]}, {32'b0, exp_rd[1]});
                if (ce_e) chk($sformatf("h%0d ram_addr", g), {56'b0, raddr}, {56'b0, hd.addr});
                if (ce_e && hd.wr) chk($sformatf("h%0d ram_wdata", g), {32'b0, rdo}, {32'b0, hd.data});
                if (fin) void'(q.pop_front());
            end
            if (rst) begin
                armed     = 1'b1;
                q.delete();
                exp_own   = 1'b0;
                exp_rd[0] = '0;
                exp_rd[1] = '0;
            end
        end

        task automatic issue(int m, bit w, logic [AW-1:0] a, logic [DW-1:0] d, int gap);
            int t;
            repeat (gap) begin @(posedge clk); #1; end
            wr[m]    = w;
            addr[m]  = a;
            wdata[m] = d;
            req[m]   = 1'b1;
            iss[m]   = iss[m] + 1;
            t = 0;
            do begin
                @(posedge clk); #1;
                t++;
                // once granted, fields (and even REQ) may wander without affecting the access
                if (scrib[m] && gnt[m] == iss[m] && !ack[m]) begin
                    addr[m]  = AW'($urandom);
                    wdata[m] = $urandom;
                    wr[m]    = 1'($urandom);
                    if ($urandom_range(0, 3) == 0) req[m] = 1'b0;
                end
            end while (!ack[m] && t < 200);
            chk($sformatf("h%0d ack%0d_seen", g, m), {63'b0, ack[m]}, 64'd1);
            req[m] = 1'b0;
        endtask

        initial begin
            int t;
            rst = 1'b1;
            done = 1'b0;
            for (int i = 0; i < 2; i++) begin
                req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; scrib[i] = 1'b0;
            end
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            // tie from reset: M0 first, then alternate (or M0 twice under fixed priority)
            fork
                begin issue(0, 1'b0, 8'h01, '0, 0); issue(0, 1'b0, 8'h01, '0, 0); end
                begin issue(1, 1'b0, 8'h02, '0, 0); issue(1, 1'b0, 8'h02, '0, 0); end
            join
            issue(0, 1'b1, 8'h10, 32'hDEADBEEF, 1);
            issue(0, 1'b0, 8'h10, '0, 0);
            issue(1, 1'b0, 8'h7F, '0, 1);
            // M0 fields scrambled during BUS/DONE
            scrib[0] = 1'b1;
            issue(0, 1'b0, 8'h10, '0, 1);
            issue(0, 1'b1, 8'h10, 32'hCAFEF00D, 0);
            scrib[0] = 1'b0;
            issue(0, 1'b0, 8'h10, '0, 0);
            issue(0, 1'b0, 8'h20, '0, 0);
            // M0 streaming while M1 waits
            fork
                begin
                    for (int i = 0; i < 4; i++) issue(0, 1'b1, 8'h30 + 8'(i), 32'h1000 + i, 0);
                end
                issue(1, 1'b0, 8'h31, '0, 1);
            join
            fork
                begin
                    for (int i = 0; i < 30; i++) begin
                        scrib[0] = 1'($urandom);
                        issue(0, 1'($urandom), pick_addr(), $urandom, $urandom_range(0, 3));
                    end
                end
                begin
                    for (int i = 0; i < 30; i++) begin
                        scrib[1] = 1'($urandom);
                        issue(1, 1'($urandom), pick_addr(), $urandom, $urandom_range(0, 3));
                    end
                end
            join
            scrib[0] = 1'b0;
            scrib[1] = 1'b0;
            // reset during the BUS cycle of an M1 read
            repeat (2) begin @(posedge clk); #1; end
            wr[1] = 1'b0; addr[1] = 8'h7F; req[1] = 1'b1; iss[1] = iss[1] + 1;
            t = 0;
            do begin @(posedge clk); #1; t++; end while (!(busy && owner) && t < 20);
            chk($sformatf("h%0d m1_bus_reached", g), {63'b0, busy && owner}, 64'd1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            req[1] = 1'b0;
            fork
                issue(0, 1'b0, 8'h02, '0, 0);
                issue(1, 1'b0, 8'h01, '0, 0);
            join
            repeat (4) begin @(posedge clk); #1; end
            chk($sformatf("h%0d queue_drained", g), 64'(q.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        fork
            wait (h[0].done && h[1].done);
            begin
                repeat (20000) @(posedge clk);
                $display("FAIL global_timeout: run incomplete, required both harnesses done");
                n_fail++;
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
